// File: rtl/mc_out_arbiter.sv
// Multicast output-port arbiter: round-robin over five RC sources feeding a DEPTH-entry output FIFO.
// Optional MC_OUT_ARB_STATS_EN adds saturating flit_cnt / stall_cnt outputs.
module mc_out_arbiter #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 2,
  parameter int DATASIZE = 30,
  parameter int PORT_DIR = 0
) (
  input  logic                rc_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in_W,
  input  logic [4:0]          direction_in_W,
  input  logic [DATASIZE-1:0] data_in_N,
  input  logic [4:0]          direction_in_N,
  input  logic [DATASIZE-1:0] data_in_L,
  input  logic [4:0]          direction_in_L,
  input  logic [DATASIZE-1:0] data_in_E,
  input  logic [4:0]          direction_in_E,
  input  logic [DATASIZE-1:0] data_in_S,
  input  logic [4:0]          direction_in_S,
  output logic [4:0]          grant,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                ready_in,
`ifdef MC_OUT_ARB_STATS_EN
  output logic [15:0]         flit_cnt,
  output logic [15:0]         stall_cnt,
`endif
  output logic [WIDTH:0]      fifo_count
);

  logic [DATASIZE-1:0] src_data [5];
  logic [4:0]          src_dir  [5];
  logic [4:0]          req;

  assign src_data[0] = data_in_W;  assign src_dir[0] = direction_in_W;
  assign src_data[1] = data_in_N;  assign src_dir[1] = direction_in_N;
  assign src_data[2] = data_in_L;  assign src_dir[2] = direction_in_L;
  assign src_data[3] = data_in_E;  assign src_dir[3] = direction_in_E;
  assign src_data[4] = data_in_S;  assign src_dir[4] = direction_in_S;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_req
      assign req[gi] = src_dir[gi][PORT_DIR];
    end
  endgenerate

  // Direction bits belonging to other output ports are intentionally ignored here.
  logic unused_dir_bits;
  assign unused_dir_bits = ^{direction_in_W, direction_in_N, direction_in_L,
                             direction_in_E, direction_in_S};

  logic [2:0]          rr_ptr_reg;
  logic [2:0]          rr_ptr_next;
  logic [WIDTH-1:0]    wr_ptr_reg;
  logic [WIDTH-1:0]    rd_ptr_reg;
  logic [WIDTH:0]      count_reg;
  logic [WIDTH:0]      count_next;
  logic [DATASIZE-1:0] mem [DEPTH];

  logic       pop;
  logic       space;
  logic       push;
  logic       found;
  logic [2:0] sel_idx;
  logic [3:0] scan_idx;

  assign valid_out  = (count_reg != '0);
  assign pop        = valid_out & ready_in;
  // DEPTH is a power of two, so the count MSB alone flags a full FIFO.
  assign space      = ~count_reg[WIDTH] | pop;
  assign data_out   = mem[rd_ptr_reg];
  assign fifo_count = count_reg;

  always_comb begin
    found    = 1'b0;
    sel_idx  = 3'd0;
    scan_idx = 4'd0;
    for (int k = 0; k < 5; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + 4'(k);
      if (scan_idx >= 4'd5) scan_idx = scan_idx - 4'd5;
      if (!found && req[scan_idx[2:0]]) begin
        found   = 1'b1;
        sel_idx = scan_idx[2:0];
      end
    end
  end

  assign push        = found & space & rst_n;
  assign grant       = push ? (5'b00001 << sel_idx) : 5'b00000;
  assign rr_ptr_next = (sel_idx == 3'd4) ? 3'd0 : sel_idx + 3'd1;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= 3'd0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        rr_ptr_reg <= rr_ptr_next;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge rc_clk) begin
    if (push) mem[wr_ptr_reg] <= src_data[sel_idx];
  end

`ifdef MC_OUT_ARB_STATS_EN
  logic [15:0] flit_cnt_reg;
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt_reg  <= 16'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      if (push && flit_cnt_reg != 16'hFFFF) flit_cnt_reg <= flit_cnt_reg + 16'd1;
      if ((req != 5'd0) && !space && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign flit_cnt  = flit_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mc_out_arbiter.sv
// Randomized self-checking bench for mc_out_arbiter against a queue-based reference model.
// Stats checks are compiled in when MC_OUT_ARB_STATS_EN is defined.
module tb_mc_out_arbiter;
  localparam int DEPTH = 4;
  localparam int WIDTH = 2;
  localparam int DW    = 30;
  localparam int PD    = 0;

  logic          rc_clk = 1'b0;
  logic          rst_n  = 1'b0;
  logic [DW-1:0] din [5];
  logic [4:0]    dir [5];
  logic [4:0]    grant;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic [WIDTH:0] fifo_count;
`ifdef MC_OUT_ARB_STATS_EN
  logic [15:0]   flit_cnt;
  logic [15:0]   stall_cnt;
`endif

  always #5 rc_clk = ~rc_clk;

  mc_out_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DW), .PORT_DIR(PD)) dut (
    .rc_clk(rc_clk), .rst_n(rst_n),
    .data_in_W(din[0]), .direction_in_W(dir[0]),
    .data_in_N(din[1]), .direction_in_N(dir[1]),
    .data_in_L(din[2]), .direction_in_L(dir[2]),
    .data_in_E(din[3]), .direction_in_E(dir[3]),
    .data_in_S(din[4]), .direction_in_S(dir[4]),
    .grant(grant), .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
`ifdef MC_OUT_ARB_STATS_EN
    .flit_cnt(flit_cnt), .stall_cnt(stall_cnt),
`endif
    .fifo_count(fifo_count)
  );

  int total = 0;
  int bad   = 0;

  // Source side: each source holds a queue of pending flits and the direction it presents.
  logic [DW-1:0] sq [5][$];
  logic [4:0]    sdir [5];

  // Reference model state.
  logic [DW-1:0] mq [$];
  int            m_rr = 0;
  int            m_flit = 0;
  int            m_stall = 0;
  int            g_idx;
  logic          m_pop, m_space, m_req_any;
  logic [4:0]    exp_grant;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [WIDTH:0] exp_count;

  task automatic drive_sources();
    for (int i = 0; i < 5; i++) begin
      if (sq[i].size() > 0) begin
        din[i] = sq[i][0];
        dir[i] = sdir[i];
      end else begin
        din[i] = '0;
        dir[i] = 5'd0;
      end
    end
  endtask

  task automatic model_eval();
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = dir[i][PD];
    exp_valid = (mq.size() > 0);
    exp_count = (WIDTH+1)'(mq.size());
    exp_data  = exp_valid ? mq[0] : '0;
    m_pop     = exp_valid && ready_in;
    m_space   = (mq.size() < DEPTH) || m_pop;
    m_req_any = (r != 5'd0);
    exp_grant = 5'd0;
    g_idx     = -1;
    if (m_space && m_req_any)
      for (int k = 0; k < 5; k++)
        if (g_idx < 0 && r[(m_rr + k) % 5]) g_idx = (m_rr + k) % 5;
    if (g_idx >= 0) exp_grant = 5'(1 << g_idx);
  endtask

  task automatic model_commit();
    if (m_pop) void'(mq.pop_front());
    if (g_idx >= 0) begin
      mq.push_back(din[g_idx]);
      m_rr = (g_idx + 1) % 5;
      void'(sq[g_idx].pop_front());
      if (m_flit < 65535) m_flit++;
    end
    if (m_req_any && !m_space && m_stall < 65535) m_stall++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_flit = 0; m_stall = 0;
    for (int i = 0; i < 5; i++) begin
      sq[i].delete();
      sdir[i] = 5'd0;
    end
  endtask

  task automatic cycle_pre();
    drive_sources();
    @(negedge rc_clk);
    model_eval();
  endtask

  task automatic cycle_post();
    @(posedge rc_clk);
    model_commit();
    #1;
  endtask

  function automatic bit pending();
    bit p = (mq.size() > 0);
    for (int i = 0; i < 5; i++) if (sq[i].size() > 0 && sdir[i][PD]) p = 1;
    return p;
  endfunction

  // Drain FIFO and matching sources with ready high, bounded.
  task automatic settle();
    int c = 0;
    ready_in = 1'b1;
    while (pending() && c < 200) begin
      cycle_pre(); cycle_post(); c++;
    end
    for (int i = 0; i < 5; i++) sq[i].delete();
    drive_sources();
    #1;
    total++;
    if (fifo_count !== 3'd0 || c >= 200) begin
      bad++;
      $display("FAIL settle_empty: fifo_count=%0d cycles=%0d required 0 within 200", fifo_count, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    sq[0].push_back(30'h123); sdir[0] = 5'b00001;
    drive_sources();
    ready_in = 1'b1;
    repeat (2) @(posedge rc_clk);
    #2;
    total++;
    if (grant !== 5'd0 || valid_out !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: grant=%b valid=%b count=%0d required 00000/0/0", grant, valid_out, fifo_count);
    end
    model_reset();
    drive_sources();
    @(negedge rc_clk);
    rst_n = 1'b1;
    @(posedge rc_clk); #1;
  endtask

  task automatic test_single();
    sq[0].push_back(30'h0000_0AAA); sdir[0] = 5'b00001;
    ready_in = 1'b1;
    cycle_pre();
    total++;
    if (grant !== 5'b00001 || grant !== exp_grant) begin
      bad++; $display("FAIL single_grant: grant=%b required 00001", grant);
    end
    cycle_post();
    cycle_pre();
    total++;
    if (valid_out !== 1'b1 || data_out !== 30'h0000_0AAA || data_out !== exp_data) begin
      bad++; $display("FAIL single_out: valid=%b data=%h required 1/0000aaa", valid_out, data_out);
    end
    cycle_post();
    cycle_pre();
    total++;
    if (fifo_count !== 3'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL single_drain: count=%0d valid=%b required 0/0", fifo_count, valid_out);
    end
    cycle_post();
  endtask

  task automatic test_rotation();
    int last_g [5];
    for (int i = 0; i < 5; i++) begin
      last_g[i] = -100;
      sdir[i] = 5'b00001;
      for (int k = 0; k < 10; k++) sq[i].push_back(DW'((i << 8) | k));
    end
    ready_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle_pre();
      total++;
      if (grant !== exp_grant || $countones(grant) != 1) begin
        bad++; $display("FAIL rotation_grant: cycle=%0d grant=%b required %b", c, grant, exp_grant);
      end
      for (int i = 0; i < 5; i++) if (grant[i]) begin
        total++;
        if (c - last_g[i] < 5) begin
          bad++; $display("FAIL rotation_fair: src=%0d granted at %0d and %0d, required gap>=5", i, last_g[i], c);
        end
        last_g[i] = c;
      end
      total++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data)) begin
        bad++; $display("FAIL rotation_out: valid=%b data=%h required %b/%h", valid_out, data_out, exp_valid, exp_data);
      end
      cycle_post();
    end
    settle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] seen [$];
    int flit_base = m_flit;
    int stall_base = m_stall;
    ready_in = 1'b0;
    sdir[0] = 5'b00001;
    for (int k = 1; k <= 6; k++) sq[0].push_back(DW'(k));
    for (int c = 0; c < 6; c++) begin
      cycle_pre();
      total++;
      if (grant !== exp_grant || fifo_count !== exp_count) begin
        bad++; $display("FAIL bp_fill: cycle=%0d grant=%b count=%0d required %b/%0d", c, grant, fifo_count, exp_grant, exp_count);
      end
      if (c >= 4) begin
        total++;
        if (grant !== 5'd0 || fifo_count !== 3'd4) begin
          bad++; $display("FAIL bp_full: cycle=%0d grant=%b count=%0d required 00000/4", c, grant, fifo_count);
        end
      end
      cycle_post();
    end
    ready_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle_pre();
      if (c == 0) begin
        total++;
        if (grant !== 5'b00001) begin
          bad++; $display("FAIL bp_pop_grant: grant=%b required 00001", grant);
        end
      end
      total++;
      if (grant !== exp_grant || valid_out !== exp_valid || fifo_count !== exp_count ||
          (exp_valid && data_out !== exp_data)) begin
        bad++; $display("FAIL bp_drain: cycle=%0d grant=%b valid=%b data=%h count=%0d required %b/%b/%h/%0d",
                        c, grant, valid_out, data_out, fifo_count, exp_grant, exp_valid, exp_data, exp_count);
      end
      if (valid_out === 1'b1) seen.push_back(data_out);
      cycle_post();
    end
    total++;
    if (seen.size() != 6) begin
      bad++; $display("FAIL bp_order_len: got=%0d flits required 6", seen.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (seen[k] !== DW'(k + 1)) begin
          bad++; $display("FAIL bp_order: idx=%0d data=%h required %h", k, seen[k], DW'(k + 1));
        end
      end
    end
`ifdef MC_OUT_ARB_STATS_EN
    total++;
    if (flit_cnt !== 16'(flit_base + 6) || stall_cnt !== 16'(stall_base + 2)) begin
      bad++; $display("FAIL bp_stats: flit_cnt=%0d stall_cnt=%0d required %0d/%0d",
                      flit_cnt, stall_cnt, flit_base + 6, stall_base + 2);
    end
`else
    if (flit_base < 0 || stall_base < 0) $display("note: negative stats base");
`endif
    settle();
  endtask

  task automatic test_filter();
    sq[0].push_back(30'h3FFF_0001); sdir[0] = 5'b00010;
    ready_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle_pre();
      total++;
      if (grant !== 5'd0 || valid_out !== 1'b0 || fifo_count !== 3'd0 || grant !== exp_grant) begin
        bad++; $display("FAIL filter: cycle=%0d grant=%b valid=%b count=%0d required 00000/0/0", c, grant, valid_out, fifo_count);
      end
      cycle_post();
    end
    sq[0].delete();
    sdir[0] = 5'd0;
  endtask

  task automatic test_async_reset();
    ready_in = 1'b0;
    sdir[1] = 5'b00001;
    for (int k = 0; k < 3; k++) sq[1].push_back(DW'(30'h100 + k));
    for (int c = 0; c < 3; c++) begin
      cycle_pre();
      total++;
      if (grant !== exp_grant) begin
        bad++; $display("FAIL areset_fill: cycle=%0d grant=%b required %b", c, grant, exp_grant);
      end
      cycle_post();
    end
    sq[2].push_back(30'h222); sdir[2] = 5'b00001;
    drive_sources();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || fifo_count !== 3'd0 || grant !== 5'd0) begin
      bad++; $display("FAIL areset_clear: valid=%b count=%0d grant=%b required 0/0/00000", valid_out, fifo_count, grant);
    end
    model_reset();
    drive_sources();
    @(negedge rc_clk);
    rst_n = 1'b1;
    @(posedge rc_clk); #1;
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sdir[i] = 5'b00001;
      sq[i].push_back(DW'(30'h300 + i));
    end
    cycle_pre();
    total++;
    if (grant !== 5'b00001 || grant !== exp_grant) begin
      bad++; $display("FAIL areset_rr: grant=%b required 00001", grant);
    end
    cycle_post();
`ifdef MC_OUT_ARB_STATS_EN
    total++;
    if (flit_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL areset_stats: flit_cnt=%0d stall_cnt=%0d required 1/0", flit_cnt, stall_cnt);
    end
`endif
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++) if (sq[i].size() == 0) begin
        int r = $urandom_range(0, 9);
        if (r < 4) begin
          sdir[i] = 5'b00001;
          sq[i].push_back(DW'($urandom));
        end else if (r < 6) begin
          sdir[i] = 5'(1 << $urandom_range(1, 4));
          sq[i].push_back(DW'($urandom));
        end
      end
      ready_in = ($urandom_range(0, 3) != 0) && !(c % 50 >= 40);
      cycle_pre();
      total++;
      if (grant !== exp_grant || valid_out !== exp_valid || fifo_count !== exp_count ||
          (exp_valid && data_out !== exp_data)) begin
        bad++; $display("FAIL random: cycle=%0d grant=%b valid=%b data=%h count=%0d required %b/%b/%h/%0d",
                        c, grant, valid_out, data_out, fifo_count, exp_grant, exp_valid, exp_data, exp_count);
      end
      cycle_post();
      // Flits for other output ports are taken elsewhere after one cycle.
      for (int i = 0; i < 5; i++)
        if (sq[i].size() > 0 && !sdir[i][PD]) void'(sq[i].pop_front());
`ifdef MC_OUT_ARB_STATS_EN
      total++;
      if (flit_cnt !== 16'(m_flit) || stall_cnt !== 16'(m_stall)) begin
        bad++; $display("FAIL random_stats: cycle=%0d flit_cnt=%0d stall_cnt=%0d required %0d/%0d",
                        c, flit_cnt, stall_cnt, m_flit, m_stall);
      end
`endif
    end
    settle();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      din[i] = '0;
      dir[i] = 5'd0;
      sdir[i] = 5'd0;
    end
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_filter();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
